fifo_wr_arbiter: RTL and testbench

- Shares the single TX-FIFO write port (WR_DATA_FIFO / WR_INC_FIFO / FIFO_FULL) among several response sources in the REF_CLK domain, such as register-file read data, 16-bit ALU results and a status/error byte.
- Uses round-robin arbitration between sources.
- Serialises each 1- or 2-byte response LSB first and respects FIFO backpressure.
- Sits between the system controller's response sources and ASYNC_FIFO's write side.

---
 rtl/fifo_wr_arbiter_pkg.sv | 33 +++
 rtl/fifo_wr_arbiter_rr.sv | 49 ++++
 rtl/fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter_pkg
// Purpose : Shared types and constants for the TX-FIFO write-port arbiter.
//           - FSM state encoding (IDLE / SEND / WAIT)
//           - Conventional requester slot assignments
//           - Default parameter values and an index-width helper
// Revision: 1.0 - initial release
// ============================================================================
package fifo_wr_arbiter_pkg;

  // FSM states of the write-port arbiter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Conventional requester slots in the system controller.
  localparam int REQ_REGF   = 0;  // register-file read data
  localparam int REQ_ALU    = 1;  // 16-bit ALU result
  localparam int REQ_STATUS = 2;  // status / error byte

  localparam int DEFAULT_NUM_REQ        = REQ_STATUS + 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Width of an index able to address n requesters (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Purely combinational round-robin pick. The winner is the first
//           asserted request at or after ptr_i, wrapping modulo NUM_REQ.
// Ports   :
//   req_i   [NUM_REQ] request vector
//   ptr_i   [IDX_W]   round-robin start index (must be < NUM_REQ)
//   gnt_o   [NUM_REQ] one-hot winner (all zero when no request)
//   idx_o   [IDX_W]   binary index of the winner (0 when no request)
//   valid_o           at least one request asserted
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = cand[IDX_W-1:0];
        gnt_o[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Purpose : Shares the single TX-FIFO write port among NUM_REQ response
//           sources (REF_CLK domain). Round-robin arbitration; each winner's
//           1- or 2-byte response is written LSB first and atomically,
//           honouring FIFO_FULL backpressure. A gap cycle (WAIT) follows
//           every write so FIFO_FULL and the requester's REQ can settle.
// Ports   :
//   CLK, RST          clock, synchronous active-high reset
//   REQ[N]            per-source request, held until GNT
//   REQ_DATA[N*2*DW]  per-source response, slice i = [i*2*DW +: 2*DW]
//   REQ_TWO_BYTE[N]   1 = send both bytes, 0 = low byte only
//   GNT[N]            one-hot pulse on the final byte's write cycle
//   FIFO_FULL         write-side full flag
//   WR_DATA_FIFO[DW]  byte presented to the FIFO
//   WR_INC_FIFO       write strobe (one byte per high cycle)
//   BUSY              FSM not in IDLE
//   ERR_TIMEOUT       stall-abort pulse (constant 0 unless the option is built)
// Option  : `define FIFO_WR_ARB_TIMEOUT_EN builds a full-stall timeout that
//           aborts the current response after TIMEOUT_CYCLES stalled cycles.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]          REQ_TWO_BYTE,
  output logic [NUM_REQ-1:0]          GNT,
  input  logic                        FIFO_FULL,
  output logic [DATA_WIDTH-1:0]       WR_DATA_FIFO,
  output logic                        WR_INC_FIFO,
  output logic                        BUSY,
  output logic                        ERR_TIMEOUT
);

  localparam int IDX_W   = idx_width(NUM_REQ);
  localparam int SLICE_W = 2 * DATA_WIDTH;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [IDX_W-1:0]      rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]      winner_q,  winner_d;
  logic [SLICE_W-1:0]    data_q,    data_d;
  logic                  two_q,     two_d;
  logic                  bidx_q,    bidx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // --------------------------------------------------------------------------
  // Round-robin pick and winner's response selection
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic [SLICE_W-1:0] w_sel_data;
  logic               w_sel_two;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (REQ),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (w_pick_oh),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  // AND-OR mux on the one-hot pick avoids a variable-base part select.
  always_comb begin
    w_sel_data = '0;
    w_sel_two  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_oh[i]) begin
        w_sel_data = w_sel_data | REQ_DATA[i*SLICE_W +: SLICE_W];
        w_sel_two  = w_sel_two  | REQ_TWO_BYTE[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write / grant qualifiers
  // --------------------------------------------------------------------------
  logic w_write;     // byte accepted by the FIFO this cycle
  logic w_last;      // current byte is the final one of the response
  logic w_timeout;   // stall limit reached this cycle
  logic w_fire;      // GNT pulse to the winner this cycle

  assign w_write = (state_q == ST_SEND) && !FIFO_FULL;
  assign w_last  = bidx_q || !two_q;
  assign w_fire  = (w_write && w_last) || w_timeout;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count value k-1 on stall cycle k, so the abort lands on stall cycle
  // TIMEOUT_CYCLES itself.
  assign w_timeout = (state_q == ST_SEND) && FIFO_FULL &&
                     (stall_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Any write or leaving SEND returns the counter to zero.
  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == ST_SEND) && FIFO_FULL && !w_timeout) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ERR_TIMEOUT = w_timeout && !RST;
`else
  // The stall limit only matters when the timeout is built in.
  logic [31:0] tmo_cycles_unused;
  assign tmo_cycles_unused = 32'(TIMEOUT_CYCLES);

  assign w_timeout   = 1'b0;
  assign ERR_TIMEOUT = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    data_d    = data_q;
    two_d     = two_q;
    bidx_d    = bidx_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        wr_data_d = '0;
        if (w_pick_valid) begin
          winner_d  = w_pick_idx;
          data_d    = w_sel_data;
          two_d     = w_sel_two;
          bidx_d    = 1'b0;
          // Low byte is registered now so it is stable for the whole SEND.
          wr_data_d = w_sel_data[DATA_WIDTH-1:0];
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (w_write) begin
          state_d = ST_WAIT;
        end else if (w_timeout) begin
          // Abort: clearing two-byte mode makes WAIT treat the response as
          // finished, so any remaining byte is dropped.
          two_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (two_q && !bidx_q) begin
          bidx_d    = 1'b1;
          wr_data_d = data_q[SLICE_W-1:DATA_WIDTH];
          state_d   = ST_SEND;
        end else begin
          rr_ptr_d  = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
          wr_data_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        wr_data_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      data_q    <= '0;
      two_q     <= 1'b0;
      bidx_q    <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      winner_q  <= winner_d;
      data_q    <= data_d;
      two_q     <= two_d;
      bidx_q    <= bidx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs - forced to zero while reset is asserted so an interrupted
  // transaction can never emit a write or grant in the reset cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    GNT = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      GNT[i] = w_fire && !RST && (winner_q == IDX_W'(i));
    end
  end

  assign WR_INC_FIFO  = w_write && !RST;
  assign WR_DATA_FIFO = RST ? '0 : wr_data_q;
  assign BUSY         = (state_q != ST_IDLE) && !RST;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Purpose : Self-checking bench for fifo_wr_arbiter: directed vector table,
//           contention sequence, optional timeout sequence, and randomized
//           traffic against a transaction-timing reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, two, gnt;
  logic [N*2*DW-1:0] rdata;
  logic            full, inc, busy, err;
  logic [DW-1:0]   wdata;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .REQ          (req),
    .REQ_DATA     (rdata),
    .REQ_TWO_BYTE (two),
    .GNT          (gnt),
    .FIFO_FULL    (full),
    .WR_DATA_FIFO (wdata),
    .WR_INC_FIFO  (inc),
    .BUSY         (busy),
    .ERR_TIMEOUT  (err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table: one row per clock cycle
  // --------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic [2:0]  rq;
    logic [47:0] d;
    logic [2:0]  tw;
    logic        f;
    logic        e_inc;
    logic [7:0]  e_d;
    logic        chk_d;
    logic [2:0]  e_gnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [47:0] d,
                              input logic [2:0] tw, input logic f, input logic ei,
                              input logic [7:0] ed, input logic cd, input logic [2:0] eg,
                              input logic eb);
    vec_t v;
    v.r = r; v.rq = rq; v.d = d; v.tw = tw; v.f = f;
    v.e_inc = ei; v.e_d = ed; v.chk_d = cd; v.e_gnt = eg; v.e_busy = eb;
    return v;
  endfunction

  localparam logic [47:0] D1  = {16'h0000, 16'h0000, 16'h00A5};
  localparam logic [47:0] D2  = {16'h0000, 16'h1234, 16'h0000};
  localparam logic [47:0] D3  = {16'h0000, 16'h0000, 16'hC3D4};
  localparam logic [47:0] D3X = {16'h5555, 16'h6666, 16'hFFFF};
  localparam logic [47:0] D4  = {16'h0000, 16'hBEEF, 16'h0000};
  localparam logic [47:0] D5  = {16'h0000, 16'hBEEF, 16'h0077};

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic [2:0] rq, input logic [47:0] d,
                       input logic [2:0] tw, input logic f);
    @(negedge clk);
    rst = r; req = rq; rdata = d; two = tw; full = f;
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Randomized phase: reference model state
  // --------------------------------------------------------------------------
  bit        m_active;
  int        m_win, m_ready, m_idle_from, m_ptr;
  logic [7:0] m_bytes[$];
  bit [N-1:0] pend, granted_prev;

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  logic [7:0] cont_bytes[$];
  logic [2:0] cont_gnts[$];

  initial begin
    logic [7:0] exp_bytes[7];
    logic [2:0] cur_req;
    int         g1;
    bit         switched;

    rst = 1'b1; req = '0; rdata = '0; two = '0; full = 1'b0;

    // ---------------- directed table ----------------
    // reset
    tbl.push_back(mk(1, 3'b000, 48'h0, 3'b000, 0, 0, 8'h00, 1, 3'b000, 0));
    tbl.push_back(mk(1, 3'b000, 48'h0, 3'b000, 0, 0, 8'h00, 1, 3'b000, 0));
    // single 1-byte request from source 0
    tbl.push_back(mk(0, 3'b001, D1, 3'b000, 0, 0, 8'h00, 1, 3'b000, 0));
    tbl.push_back(mk(0, 3'b001, D1, 3'b000, 0, 1, 8'hA5, 1, 3'b001, 1));
    tbl.push_back(mk(0, 3'b000, D1, 3'b000, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, D1, 3'b000, 0, 0, 8'h00, 1, 3'b000, 0));
    // single 2-byte request from source 1
    tbl.push_back(mk(0, 3'b010, D2, 3'b010, 0, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, D2, 3'b010, 0, 1, 8'h34, 1, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, D2, 3'b010, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, D2, 3'b010, 0, 1, 8'h12, 1, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, D2, 3'b000, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, D2, 3'b000, 0, 0, 8'h00, 0, 3'b000, 0));
    // backpressure: 2-byte from source 0 (pointer wraps from 2), 5 full cycles;
    // inputs change after capture and must be ignored
    tbl.push_back(mk(0, 3'b001, D3, 3'b001, 0, 0, 8'h00, 0, 3'b000, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 3'b001, D3X, 3'b000, 1, 0, 8'hD4, 1, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, D3X, 3'b000, 0, 1, 8'hD4, 1, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, D3X, 3'b000, 1, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, D3X, 3'b000, 1, 0, 8'hC3, 1, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, D3X, 3'b000, 0, 1, 8'hC3, 1, 3'b001, 1));
    tbl.push_back(mk(0, 3'b000, D3X, 3'b000, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 48'h0, 3'b000, 0, 0, 8'h00, 0, 3'b000, 0));
    // reset in the WAIT after the low byte of BEEF
    tbl.push_back(mk(0, 3'b010, D4, 3'b010, 0, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, D4, 3'b010, 0, 1, 8'hEF, 1, 3'b000, 1));
    tbl.push_back(mk(1, 3'b010, D4, 3'b010, 0, 0, 8'h00, 1, 3'b000, 0));
    tbl.push_back(mk(0, 3'b011, D5, 3'b010, 0, 0, 8'h00, 1, 3'b000, 0));
    tbl.push_back(mk(0, 3'b011, D5, 3'b010, 0, 1, 8'h77, 1, 3'b001, 1));
    tbl.push_back(mk(0, 3'b010, D5, 3'b010, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, D5, 3'b010, 0, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, D5, 3'b010, 0, 1, 8'hEF, 1, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, D5, 3'b010, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, D5, 3'b010, 0, 1, 8'hBE, 1, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, D5, 3'b000, 0, 0, 8'h00, 0, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, D5, 3'b000, 0, 0, 8'h00, 1, 3'b000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].d, tbl[i].tw, tbl[i].f);
      check($sformatf("tbl[%0d].inc", i),  32'(inc),  32'(tbl[i].e_inc));
      check($sformatf("tbl[%0d].gnt", i),  32'(gnt),  32'(tbl[i].e_gnt));
      check($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl[%0d].err", i),  32'(err),  32'(0));
      if (tbl[i].chk_d)
        check($sformatf("tbl[%0d].data", i), 32'(wdata), 32'(tbl[i].e_d));
    end

    // ---------------- contention sequence ----------------
    drive(1, 3'b000, 48'h0, 3'b000, 0);
    drive(1, 3'b000, 48'h0, 3'b000, 0);
    cur_req  = 3'b111;
    g1       = 0;
    switched = 1'b0;
    for (int c = 0; c < 80 && cont_bytes.size() < 7; c++) begin
      drive(0, cur_req, {16'h0033, 16'h0022, 16'h0011}, 3'b000, 0);
      if (inc) begin
        cont_bytes.push_back(wdata);
        cont_gnts.push_back(gnt);
      end
      if (gnt[REQ_ALU]) g1++;
      if (g1 == 2 && !switched) begin
        cur_req  = 3'b011;
        switched = 1'b1;
      end
    end
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h11, 8'h22};
    check("contention.count", 32'(cont_bytes.size()), 32'(7));
    for (int i = 0; i < 7 && i < cont_bytes.size(); i++) begin
      check($sformatf("contention.byte[%0d]", i), 32'(cont_bytes[i]), 32'(exp_bytes[i]));
      check($sformatf("contention.gnt[%0d]", i), 32'(cont_gnts[i]),
            32'(1) << ((exp_bytes[i] >> 4) - 1));
    end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    // ---------------- full-stall timeout ----------------
    drive(1, 3'b000, 48'h0, 3'b000, 0);
    drive(0, 3'b100, {16'hABCD, 32'h0}, 3'b100, 1);
    check("tmo.idle_busy", 32'(busy), 32'(0));
    for (int s = 1; s <= TMO; s++) begin
      drive(0, 3'b100, {16'hABCD, 32'h0}, 3'b100, 1);
      check($sformatf("tmo.inc[%0d]", s), 32'(inc), 32'(0));
      check($sformatf("tmo.err[%0d]", s), 32'(err), 32'(s == TMO));
      check($sformatf("tmo.gnt[%0d]", s), 32'(gnt), (s == TMO) ? 32'(3'b100) : 32'(0));
    end
    drive(0, 3'b000, 48'h0, 3'b000, 1);
    check("tmo.wait_busy", 32'(busy), 32'(1));
    check("tmo.wait_inc", 32'(inc), 32'(0));
    drive(0, 3'b000, 48'h0, 3'b000, 1);
    check("tmo.idle_after", 32'(busy), 32'(0));
`endif

    // ---------------- randomized traffic vs reference model ----------------
    drive(1, 3'b000, 48'h0, 3'b000, 0);
    m_active = 0; m_ptr = 0; m_idle_from = 0; m_bytes.delete();
    pend = '0; granted_prev = '0;
    for (int n = 1; n <= 2000; n++) begin
      logic        r, f, e_inc, e_busy, chk_d;
      logic [2:0]  e_gnt;
      logic [7:0]  e_d;
      logic [47:0] d;
      logic [2:0]  tw;
      logic [15:0] sl;

      r = ($urandom % 300) == 0;
      for (int i = 0; i < N; i++) begin
        if (granted_prev[i]) pend[i] = 1'b0;
        else if (!pend[i] && ($urandom % 4) == 0) pend[i] = 1'b1;
      end
      d  = {16'($urandom), 16'($urandom), 16'($urandom)};
      tw = 3'($urandom);
      f  = ($urandom % 4) == 0;
      drive(r, pend, d, tw, f);

      e_inc = 0; e_gnt = '0; e_d = '0; chk_d = 0;
      granted_prev = '0;
      if (r) begin
        e_busy = 0; chk_d = 1;
        m_active = 0; m_ptr = 0; m_idle_from = n + 1; m_bytes.delete();
      end else begin
        e_busy = m_active || (n < m_idle_from);
        if (m_active && n >= m_ready) begin
          chk_d = 1;
          e_d   = m_bytes[0];
          if (!f) begin
            e_inc = 1;
            void'(m_bytes.pop_front());
            if (m_bytes.size() == 0) begin
              e_gnt             = 3'(1 << m_win);
              granted_prev[m_win] = 1'b1;
              m_ptr             = (m_win + 1) % N;
              m_active          = 0;
              m_idle_from       = n + 2;
            end else begin
              m_ready = n + 2;
            end
          end
        end else if (!m_active && n >= m_idle_from && |pend) begin
          m_win = rr_pick(pend, m_ptr);
          sl    = d[m_win*16 +: 16];
          m_bytes.push_back(sl[7:0]);
          if (tw[m_win]) m_bytes.push_back(sl[15:8]);
          m_active = 1;
          m_ready  = n + 1;
        end
      end

      check("rand.inc",  32'(inc),  32'(e_inc));
      check("rand.gnt",  32'(gnt),  32'(e_gnt));
      check("rand.busy", 32'(busy), 32'(e_busy));
      check("rand.err",  32'(err),  32'(0));
      if (chk_d) check("rand.data", 32'(wdata), 32'(e_d));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
